mips_timer_mmio: RTL

//  Memory-mapped I/O stage between the single-cycle MIPS core's data port and the data RAM.

---
 rtl/mips_timer_mmio.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_timer_mmio.sv
// rtl/mips_timer_mmio.sv - MMIO decode between the MIPS data port and RAM, with a compare/match timer
// Loads from the I/O page return timer registers and all other loads return RAM data, with no added latency.
module mips_timer_mmio #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
    parameter int          CNT_W   = 32,
    parameter int          PRE_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state_q, state_d;
    logic               autoreload_q, autoreload_d;
    logic               irqen_q, irqen_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   compare_q, compare_d;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               match_q, match_d;
    logic               ovf_q, ovf_d;

    logic               io_sel, io_wr, tick, match_set, ovf_set;
    logic               wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
    logic [31:0]        io_rdata;

    assign io_sel      = (memaddr[31:8] == IO_BASE[31:8]);
    assign io_wr       = memwrite & io_sel;
    assign wr_ctrl     = io_wr && (memaddr[7:2] == 6'h00);
    assign wr_count    = io_wr && (memaddr[7:2] == 6'h01);
    assign wr_compare  = io_wr && (memaddr[7:2] == 6'h02);
    assign wr_status   = io_wr && (memaddr[7:2] == 6'h03);
    assign wr_prescale = io_wr && (memaddr[7:2] == 6'h04);

    assign ram_we      = memwrite & ~io_sel;
    assign ram_addr    = memaddr;
    assign ram_wdata   = memwritedata;
    assign memreaddata = io_sel ? io_rdata : ram_rdata;
    assign irq         = irqen_q & match_q;

    // EN is not stored: it reads back as "currently running", so HALT shows EN=0
    always_comb begin
        io_rdata = 32'h0;
        case (memaddr[7:2])
            6'h00:   io_rdata = {29'h0, irqen_q, autoreload_q, state_q == RUN};
            6'h01:   io_rdata = 32'(count_q);
            6'h02:   io_rdata = 32'(compare_q);
            6'h03:   io_rdata = {30'h0, ovf_q, match_q};
            6'h04:   io_rdata = 32'(prescale_q);
            default: io_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        autoreload_d = autoreload_q;
        irqen_d      = irqen_q;
        count_d      = count_q;
        compare_d    = compare_q;
        prescale_d   = prescale_q;
        pre_d        = pre_q;
        tick         = 1'b0;
        match_set    = 1'b0;
        ovf_set      = 1'b0;

        if (state_q == RUN) begin
            if (pre_q == prescale_q) begin
                tick  = 1'b1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (autoreload_q) begin
                    count_d = '0;
                end else begin
                    state_d = HALT;
                end
            end else begin
                count_d = count_q + 1'b1;
                ovf_set = &count_q;
            end
        end

        // Software writes are applied after the tick so they take priority
        if (wr_count) begin
            count_d = memwritedata[CNT_W-1:0];
            pre_d   = '0;
        end
        if (wr_prescale) begin
            prescale_d = memwritedata[PRE_W-1:0];
            pre_d      = '0;
        end
        if (wr_compare) begin
            compare_d = memwritedata[CNT_W-1:0];
        end
        if (wr_ctrl) begin
            autoreload_d = memwritedata[1];
            irqen_d      = memwritedata[2];
            state_d      = memwritedata[0] ? RUN : IDLE;
        end

        match_d = (match_q & ~(wr_status & memwritedata[0])) | match_set;
        ovf_d   = (ovf_q   & ~(wr_status & memwritedata[1])) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            autoreload_q <= 1'b0;
            irqen_q      <= 1'b0;
            count_q      <= '0;
            compare_q    <= '1;
            prescale_q   <= '0;
            pre_q        <= '0;
            match_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            autoreload_q <= autoreload_d;
            irqen_q      <= irqen_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            prescale_q   <= prescale_d;
            pre_q        <= pre_d;
            match_q      <= match_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule
